matmul4_seq: RTL and testbench

Sequencer that computes a full 4x4 signed fixed-point matrix product C = A·B by time-sharing one 4-term dot-product datapath across the 16 output coefficients. The datapath is four Q-format multipliers feeding an adder, the same arithmetic the coefficient stage performs. The block latches both operands on a start handshake and walks row/column indices through that datapath, one coefficient per cycle. It accumulates results into an output matrix register and reports completion and a sticky overflow flag. It sits between the Kalman filter control FSM and the matrix arithmetic, and serves every 4x4 product in the filter update.

---
 rtl/matmul4_seq_if.sv | 25 ++
 rtl/matmul4_seq.sv | 151 +++++++++++++++
 tb/tb_matmul4_seq.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/matmul4_seq_if.sv
// matmul4_seq_if: start/operand/result bundle for the 4x4 matrix-product sequencer.
// master = requester (filter control FSM), slave = matmul4_seq.
interface matmul4_seq_if #(
  parameter int unsigned N = 32,
  parameter int unsigned P = 4
);
  logic             start;
  logic [P*P*N-1:0] a_in;
  logic [P*P*N-1:0] b_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [P*P*N-1:0] c_out;
  logic             overflow;

  modport master (
    output start, a_in, b_in,
    input  ready, busy, done, c_out, overflow
  );

  modport slave (
    input  start, a_in, b_in,
    output ready, busy, done, c_out, overflow
  );
endinterface

// File: rtl/matmul4_seq.sv
// matmul4_seq: computes C = A*B for 4x4 signed Q-format matrices by time-sharing
// one 4-term dot-product datapath, one output coefficient per RUN cycle.
// Optional build macro: MATMUL_PIPE_EN adds a register stage between the dot
// product and the c_out write port (one extra drain cycle in RUN).
module matmul4_seq #(
  parameter int unsigned N = 32,
  parameter int unsigned Q = 18,
  parameter int unsigned P = 4
) (
  input logic          clk,
  input logic          reset,
  matmul4_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [P*P*N-1:0] a_reg;
  logic [P*P*N-1:0] b_reg;
  logic [P*P*N-1:0] c_reg;
  logic [3:0]       idx;
  logic             ovf_reg;
  logic             ready_q;
  logic             done_q;

  logic [1:0]              row;
  logic [1:0]              col;
  logic signed [N-1:0]     a_el;
  logic signed [N-1:0]     b_el;
  logic signed [2*N-1:0]   prod;
  logic signed [2*N-1:0]   shifted;
  logic [N-1:0]            dot;
  logic                    dot_ovf;

`ifdef MATMUL_PIPE_EN
  logic         pipe_vld;
  logic [3:0]   pipe_idx;
  logic [N-1:0] pipe_dot;
  logic         pipe_ovf;
  logic         drain;
`endif

  assign row = idx[3:2];
  assign col = idx[1:0];

  // Dot product of row 'row' of A with column 'col' of B; sum wraps mod 2^N.
  always_comb begin
    a_el    = '0;
    b_el    = '0;
    prod    = '0;
    shifted = '0;
    dot     = '0;
    dot_ovf = 1'b0;
    for (int unsigned k = 0; k < P; k++) begin
      a_el    = a_reg[32'({row, k[1:0]}) * N +: N];
      b_el    = b_reg[32'({k[1:0], col}) * N +: N];
      prod    = a_el * b_el;
      shifted = prod >>> Q;
      dot     = dot + shifted[N-1:0];
      // Product overflows when the shifted value is not a sign extension of its low N bits.
      if (shifted != {{N{shifted[N-1]}}, shifted[N-1:0]})
        dot_ovf = 1'b1;
    end
  end

  // Sequencer FSM, operand capture, result write-back and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      c_reg   <= '0;
      idx     <= '0;
      ovf_reg <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef MATMUL_PIPE_EN
      pipe_vld <= 1'b0;
      pipe_idx <= '0;
      pipe_dot <= '0;
      pipe_ovf <= 1'b0;
      drain    <= 1'b0;
`endif
    end else begin
`ifdef MATMUL_PIPE_EN
      // Write stage: retire the coefficient issued in the previous cycle.
      if (pipe_vld) begin
        c_reg[32'(pipe_idx) * N +: N] <= pipe_dot;
        ovf_reg                       <= ovf_reg | pipe_ovf;
      end
`endif
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_reg   <= bus.a_in;
            b_reg   <= bus.b_in;
            idx     <= '0;
            ovf_reg <= 1'b0;
            ready_q <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
`ifdef MATMUL_PIPE_EN
          // Issue 16 coefficients into the stage, then one drain cycle for idx 15.
          if (!drain) begin
            pipe_vld <= 1'b1;
            pipe_idx <= idx;
            pipe_dot <= dot;
            pipe_ovf <= dot_ovf;
            idx      <= idx + 4'd1;
            if (idx == 4'd15)
              drain <= 1'b1;
          end else begin
            pipe_vld <= 1'b0;
            drain    <= 1'b0;
            done_q   <= 1'b1;
            state    <= DONE;
          end
`else
          c_reg[32'(idx) * N +: N] <= dot;
          ovf_reg                  <= ovf_reg | dot_ovf;
          idx                      <= idx + 4'd1;
          if (idx == 4'd15) begin
            done_q <= 1'b1;
            state  <= DONE;
          end
`endif
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready    = ready_q;
  assign bus.busy     = ~ready_q;
  assign bus.done     = done_q;
  assign bus.c_out    = c_reg;
  assign bus.overflow = ovf_reg;

endmodule

// File: tb/tb_matmul4_seq.sv
// tb_matmul4_seq: directed checks of matmul4_seq with hand-derived result matrices.
module tb_matmul4_seq;
  localparam int unsigned N = 32;
  localparam int unsigned P = 4;
  localparam int unsigned W = P*P*N;
`ifdef MATMUL_PIPE_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  matmul4_seq_if #(.N(N), .P(P)) bus ();

  matmul4_seq #(.N(N), .Q(18), .P(P)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Per-job observations
  int           r_done_cyc;
  int           r_n_done;
  logic         r_ready_acc;
  logic         r_ovf_c1;
  logic [W-1:0] r_c_c1;
  logic         r_busy_done;
  logic         r_ready_done;
  logic         r_ovf_done;
  logic         r_ready_after;

  logic [W-1:0] m_id, m_seq, m_one, m_two, m_neg1, m_half, m_ovf, m_zero;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] fill(input logic [N-1:0] v);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) m[i*N +: N] = v;
    return m;
  endfunction

  // Start a job and watch it for LAT+4 cycles (bounded; no done => r_done_cyc = -1).
  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit scramble, input bit inject);
    @(negedge clk);
    r_ready_acc = bus.ready;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (scramble) begin
      bus.a_in = ~a;
      bus.b_in = ~b;
    end
    r_ovf_c1      = bus.overflow;
    r_c_c1        = bus.c_out;
    r_done_cyc    = -1;
    r_n_done      = 0;
    r_busy_done   = 1'b0;
    r_ready_done  = 1'b1;
    r_ovf_done    = 1'b0;
    r_ready_after = 1'b0;
    for (int cyc = 1; cyc <= LAT + 4; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (inject && cyc == 5) begin
        bus.start = 1'b1;
        bus.a_in  = m_neg1;
        bus.b_in  = m_half;
      end
      if (inject && cyc == 6) bus.start = 1'b0;
      if (r_done_cyc > 0 && cyc == r_done_cyc + 1) r_ready_after = bus.ready;
      if (bus.done) begin
        r_n_done++;
        if (r_done_cyc < 0) begin
          r_done_cyc   = cyc;
          r_busy_done  = bus.busy;
          r_ready_done = bus.ready;
          r_ovf_done   = bus.overflow;
        end
      end
    end
  endtask

  initial begin
    m_zero = '0;
    m_id   = '0;
    m_seq  = '0;
    m_ovf  = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        m_seq[(r*4+c)*N +: N] = 32'((r*4 + c + 1) << 18);
        if (r == c) m_id[(r*4+c)*N +: N] = 32'h0004_0000;
      end
    m_one  = fill(32'h0004_0000);
    m_two  = fill(32'h0008_0000);
    m_neg1 = fill(32'hFFFC_0000);
    m_half = fill(32'h0002_0000);
    m_ovf[N-1:0] = 32'h4000_0000;

    reset     = 1'b0;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", W'(bus.ready), W'(1'b1));
    chk("rst_busy",  W'(bus.busy),  W'(1'b0));
    chk("rst_done",  W'(bus.done),  W'(1'b0));
    chk("rst_cout",  bus.c_out, m_zero);
    chk("rst_ovf",   W'(bus.overflow), W'(1'b0));
    reset = 1'b1;

    // Identity, inputs scrambled after acceptance
    run_job(m_id, m_seq, 1'b1, 1'b0);
    chk("id_ready_acc",   W'(r_ready_acc), W'(1'b1));
    chk("id_done_cyc",    W'(r_done_cyc), W'(LAT));
    chk("id_n_done",      W'(r_n_done), W'(1));
    chk("id_busy_done",   W'(r_busy_done), W'(1'b1));
    chk("id_ready_done",  W'(r_ready_done), W'(1'b0));
    chk("id_ready_after", W'(r_ready_after), W'(1'b1));
    chk("id_cout",        bus.c_out, m_seq);
    chk("id_ovf",         W'(bus.overflow), W'(1'b0));

    // Constant 1.0 x 2.0; c_out must not be cleared at start
    run_job(m_one, m_two, 1'b0, 1'b0);
    chk("const_c_at_c1", r_c_c1, m_seq);
    chk("const_cout",    bus.c_out, fill(32'h0020_0000));
    chk("const_ovf",     W'(bus.overflow), W'(1'b0));

    // Signed -1.0 x 0.5
    run_job(m_neg1, m_half, 1'b0, 1'b0);
    chk("signed_cout", bus.c_out, fill(32'hFFF8_0000));
    chk("signed_ovf",  W'(bus.overflow), W'(1'b0));

    // Overflow: 4096.0 * 4096.0 in element (0,0)
    run_job(m_ovf, m_ovf, 1'b0, 1'b0);
    chk("ovf_done_cyc", W'(r_done_cyc), W'(LAT));
    chk("ovf_at_done",  W'(r_ovf_done), W'(1'b1));
    chk("ovf_held",     W'(bus.overflow), W'(1'b1));
    chk("ovf_cout",     bus.c_out, m_zero);

    // Identity after overflow clears the flag
    run_job(m_id, m_seq, 1'b0, 1'b0);
    chk("clr_ovf_c1",   W'(r_ovf_c1), W'(1'b0));
    chk("clr_ovf_done", W'(r_ovf_done), W'(1'b0));
    chk("clr_cout",     bus.c_out, m_seq);

    // Start with different operands in cycle 5 is ignored
    run_job(m_one, m_two, 1'b0, 1'b1);
    chk("inj_cout",     bus.c_out, fill(32'h0020_0000));
    chk("inj_n_done",   W'(r_n_done), W'(1));
    chk("inj_done_cyc", W'(r_done_cyc), W'(LAT));

    // Reset asserted in cycle 8 of RUN
    @(negedge clk);
    bus.a_in  = m_neg1;
    bus.b_in  = m_half;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_ready", W'(bus.ready), W'(1'b1));
    chk("mid_busy",  W'(bus.busy),  W'(1'b0));
    chk("mid_done",  W'(bus.done),  W'(1'b0));
    chk("mid_cout",  bus.c_out, m_zero);
    chk("mid_ovf",   W'(bus.overflow), W'(1'b0));
    reset = 1'b1;

    run_job(m_id, m_seq, 1'b0, 1'b0);
    chk("post_rst_done_cyc", W'(r_done_cyc), W'(LAT));
    chk("post_rst_cout",     bus.c_out, m_seq);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
